// File: rtl/fifo_sync_param.sv
// Parameterised single-clock FIFO with occupancy count, almost flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is a registered read.
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR     = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wen,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ren,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ADDR:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0] AF_C    = (ADDR+1)'(AF_LEVEL);
    localparam logic [ADDR:0] AE_C    = (ADDR+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR:0]    wptr;
    logic [ADDR:0]    rptr;
    logic             wr_ok;
    logic             rd_ok;

    // Extra wrap bit on each pointer makes the modular difference span 0..DEPTH.
    assign count        = wptr - rptr;
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    assign wr_ok = wen && !full;
    assign rd_ok = ren && !empty;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr[ADDR-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            overflow  <= wen && full;
            underflow <= ren && empty;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is shown straight from the array; forced to zero while empty so it never reads X.
    assign data_out = empty ? '0 : mem[rptr[ADDR-1:0]];
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
        end else if (rd_ok) begin
            data_out <= mem[rptr[ADDR-1:0]];
        end
    end
`endif

endmodule
